// File: rtl/layer_seq_c.sv
// Time-multiplexed layer sequencer: issues per-neuron operands to one shared neuron
// and captures its activations into y_all. Optional argmax tracking: LAYER_SEQ_ARGMAX_EN.
//
// state | meaning
// IDLE  | waiting for start; weight writes accepted
// ISSUE | presenting weights/bias of neuron issue_cnt each enabled cycle
// DRAIN | all neurons issued, waiting for remaining captures
// DONE  | full output vector valid for one enabled cycle
module layer_seq_c #(
    parameter int WIDTH       = 32,
    parameter int NUM_NEURONS = 3,
    parameter int NEURON_LAT  = 3,
    localparam int AW = $clog2(4*NUM_NEURONS),
    localparam int CW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic [WIDTH-1:0]             a_1,
    input  logic [WIDTH-1:0]             a_2,
    input  logic [WIDTH-1:0]             a_3,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         n_en,
    output logic [WIDTH-1:0]             n_a_1,
    output logic [WIDTH-1:0]             n_a_2,
    output logic [WIDTH-1:0]             n_a_3,
    output logic [WIDTH-1:0]             n_w_1,
    output logic [WIDTH-1:0]             n_w_2,
    output logic [WIDTH-1:0]             n_w_3,
    output logic [WIDTH-1:0]             n_b,
    input  logic [WIDTH-1:0]             n_y,
    output logic [NUM_NEURONS*WIDTH-1:0] y_all,
    output logic                         busy,
    output logic                         done
`ifdef LAYER_SEQ_ARGMAX_EN
    ,
    output logic [CW-1:0]                max_idx,
    output logic [WIDTH-1:0]             max_val
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                          state, state_d;
    logic [CW-1:0]                   issue_cnt, cap_cnt;
    logic [NEURON_LAT-1:0]           vpipe, vpipe_d;
    logic [4*NUM_NEURONS*WIDTH-1:0]  wmem;
    logic                            push, capture, last_cap, accept;

    assign n_en     = en;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign accept   = en && start && (state == IDLE);
    assign capture  = en && vpipe[NEURON_LAT-1];
    assign last_cap = capture && (cap_cnt == CW'(NUM_NEURONS-1));

    always_comb begin
        state_d = state;
        push    = 1'b0;
        case (state)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                push = 1'b1;
                if (issue_cnt == CW'(NUM_NEURONS-1)) state_d = DRAIN;
            end
            DRAIN: state_d = DRAIN;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // the final capture wins over any issue-side transition
        if (last_cap) state_d = DONE;
        vpipe_d    = vpipe << 1;
        vpipe_d[0] = push;
    end

    always_comb begin
        n_w_1 = '0;
        n_w_2 = '0;
        n_w_3 = '0;
        n_b   = '0;
        if (state == ISSUE) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (issue_cnt == CW'(k)) begin
                    n_w_1 = wmem[(4*k+0)*WIDTH +: WIDTH];
                    n_w_2 = wmem[(4*k+1)*WIDTH +: WIDTH];
                    n_w_3 = wmem[(4*k+2)*WIDTH +: WIDTH];
                    n_b   = wmem[(4*k+3)*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            vpipe     <= '0;
            wmem      <= '0;
            y_all     <= '0;
            n_a_1     <= '0;
            n_a_2     <= '0;
            n_a_3     <= '0;
`ifdef LAYER_SEQ_ARGMAX_EN
            max_idx   <= '0;
            max_val   <= '0;
`endif
        end else if (en) begin
            state <= state_d;
            vpipe <= vpipe_d;
            if (accept) begin
                n_a_1     <= a_1;
                n_a_2     <= a_2;
                n_a_3     <= a_3;
                issue_cnt <= '0;
                cap_cnt   <= '0;
            end
            if (state == ISSUE) issue_cnt <= issue_cnt + 1'b1;
            if (state == IDLE && wr_en) begin
                for (int i = 0; i < 4*NUM_NEURONS; i++) begin
                    if (wr_addr == AW'(i)) wmem[i*WIDTH +: WIDTH] <= wr_data;
                end
            end
            if (capture) begin
                cap_cnt <= cap_cnt + 1'b1;
                for (int k = 0; k < NUM_NEURONS; k++) begin
                    if (cap_cnt == CW'(k)) y_all[k*WIDTH +: WIDTH] <= n_y;
                end
`ifdef LAYER_SEQ_ARGMAX_EN
                // strict compare so ties keep the lower index
                if (cap_cnt == '0 || $signed(n_y) > $signed(max_val)) begin
                    max_idx <= cap_cnt;
                    max_val <= n_y;
                end
`endif
            end
        end
    end

endmodule

// File: doc/layer_seq_c.md
Name: layer_seq_c

Overview:
Time-multiplexed layer sequencer for one neuron_c-style datapath (Q8.24, 3 inputs, bias, pipelined multiply/add/sigmoid).
- Upstream side: holds per-neuron weights and biases, latches the layer input vector, and issues one neuron's operands per cycle.
- Downstream side: tracks issued operands through the neuron latency and captures each activation into an output vector register.
- Sits between the previous layer's output vector and the shared neuron instance. Raises done when the full layer vector is valid.

Parameters:
WIDTH, 32, data word width (Q8.24 signed)
NUM_NEURONS, 3, neurons evaluated per layer pass (>=1)
NEURON_LAT, 3, cycles from operands presented to matching n_y valid (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  global pipeline enable; 0 freezes all state
start  in  1  begin layer pass (sampled only in IDLE with en=1)
a_1, a_2, a_3  in  WIDTH each  layer input vector, latched on accepted start
wr_en  in  1  weight memory write strobe
wr_addr  in  clog2(4*NUM_NEURONS)  word address: neuron k at 4k+0..3 = w_1, w_2, w_3, b
wr_data  in  WIDTH  write data
n_en  out  1  enable to neuron; equals en
n_a_1, n_a_2, n_a_3  out  WIDTH each  latched inputs to neuron
n_w_1, n_w_2, n_w_3, n_b  out  WIDTH each  weights/bias of issued neuron; 0 outside ISSUE
n_y  in  WIDTH  neuron activation output
y_all  out  NUM_NEURONS*WIDTH  captured outputs; neuron k at [k*WIDTH +: WIDTH]
busy  out  1  high when state != IDLE
done  out  1  high in DONE state

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; a latches, counters, valid shift register, weight memory and y_all cleared.
- Stall: when en=0, FSM, counters, valid pipe, y_all, a latches and memory writes all hold. n_en=0.
- Weight writes: accepted only in IDLE with en=1. Dropped silently when busy. Out-of-range address is ignored.
- FSM states:
  - IDLE: start&en latches a_1..a_3, clears issue_cnt and cap_cnt, goes to ISSUE.
  - ISSUE: each enabled cycle drives the weights of neuron issue_cnt, pushes 1 into a NEURON_LAT-deep valid pipe, and increments issue_cnt. After issuing NUM_NEURONS-1 goes to DRAIN. Pushes 0 in all other states.
  - DRAIN: waits for captures.
  - DONE: one enabled cycle, then IDLE.
- Capture: on each enabled cycle where the valid pipe output is 1, y_all[cap_cnt] <= n_y and cap_cnt++. The capture of index NUM_NEURONS-1 moves the FSM to DONE. This can occur from ISSUE if NUM_NEURONS is small; DONE has priority.
- Timing: start high in cycle 0 → neuron k operands in cycle 1+k → n_y captured at end of cycle 1+k+NEURON_LAT → done high in cycle NUM_NEURONS+NEURON_LAT+1 (7 at defaults).
- done holds high while stalled in DONE. y_all holds until the next accepted start's first capture. A new start is accepted in the cycle after done.
- start while busy is ignored. No arithmetic is performed in this block; values pass through unmodified.

Optional Feature:
Macro LAYER_SEQ_ARGMAX_EN.
- Defined: adds outputs max_idx (clog2(NUM_NEURONS)) and max_val (WIDTH).
  - Updated on each capture using a signed compare; the first capture of a pass loads unconditionally.
  - Ties keep the lower index. Both are valid when done is high and reset to 0.
- Undefined: ports and logic are absent.

Test Plan:
- Reset: assert rst mid-cycle → busy=0, done=0, y_all=0, n_w_*/n_b=0 immediately (async).
- Bench neuron stub returns n_b delayed NEURON_LAT cycles. Biases 0x01000000, 0x02000000, 0x03000000 → y_all words in that order, busy high cycles 1..7, done high only in cycle 7.
- Same load with en=0 for cycles 2-3 → done in cycle 9, identical y_all, n_en low those cycles.
- Pulse start again at cycle 3 and write bias0=0x7F000000 at cycle 4 → both ignored; a second pass still yields 0x01000000 at word 0.
- rst during ISSUE (cycle 2) → IDLE, y_all=0, memory cleared; next pass with no writes yields all-zero y_all.
- LAYER_SEQ_ARGMAX_EN: biases 0x01000000, 0x03000000, 0xFE000000 → max_idx=1, max_val=0x03000000 at done. With equal biases 0x02000000 → max_idx=0.
